axis_scan: RTL and testbench

AXIS_SCAN -- requirements
Module: axis_scan

---
 rtl/axis_scan_pkg.sv | 33 +++
 rtl/axis_scan_if.sv | 37 +++
 rtl/axis_scan_spi_shift16.sv | 116 +++++++++++
 rtl/axis_scan.sv | 103 ++++++++++
 tb/tb_axis_scan.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_scan_pkg.sv
// Shared definitions for the axis_scan sensor poller: FSM encoding, SPI frame layout
// and default sensor register addresses.
package axis_scan_pkg;

    typedef enum logic [1:0] {
        StInit,
        StWait,
        StRead,
        StDone
    } state_e;

    localparam int unsigned FrameLen = 16;
    localparam int unsigned RwBit    = 15;
    localparam int unsigned MbBit    = 14;

    localparam logic [5:0] DefRdAddr   = 6'h32;
    localparam logic [5:0] DefInitAddr = 6'h2D;
    localparam logic [7:0] DefInitData = 8'h08;

    // Assemble one SPI command word: R/W flag, multi-byte flag (always 0), address, data.
    function automatic logic [FrameLen-1:0] build_frame(input logic       rw,
                                                        input logic [5:0] addr,
                                                        input logic [7:0] data);
        logic [FrameLen-1:0] f;
        f        = '0;
        f[RwBit] = rw;
        f[MbBit] = 1'b0;
        f[13:8]  = addr;
        f[7:0]   = data;
        return f;
    endfunction

endpackage

// File: rtl/axis_scan_if.sv
// Consumer handshake plus SPI pins of axis_scan, bundled as one interface.
interface axis_scan_if;

    logic       TIC;
    logic       RESCAN;
    logic       COMPLETED;
    logic [7:0] XREG;
    logic       nCS;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;

    // Environment side: drives strobes and the sensor's MISO line.
    modport master (
        output TIC,
        output RESCAN,
        output MISO,
        input  COMPLETED,
        input  XREG,
        input  nCS,
        input  SCLK,
        input  MOSI
    );

    // Scanner side.
    modport slave (
        input  TIC,
        input  RESCAN,
        input  MISO,
        output COMPLETED,
        output XREG,
        output nCS,
        output SCLK,
        output MOSI
    );

endinterface

// File: rtl/axis_scan_spi_shift16.sv
// 16-bit SPI mode-3 shifter with integrated SCLK divider. A frame is split into
// 34 half-periods of CLK_DIV cycles: a lead-in, 32 SCLK halves, and a tail.
// After each frame nCS is held high for 2*CLK_DIV cycles before a new start is accepted.
module axis_scan_spi_shift16
    import axis_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [FrameLen-1:0] tx_i,
    input  logic                miso_i,
    output logic                ready_o,
    output logic                done_o,
    output logic [7:0]          rx_o,
    output logic                ncs_o,
    output logic                sclk_o,
    output logic                mosi_o
);

    localparam logic [7:0] DivLast   = 8'(CLK_DIV - 1);
    localparam logic [8:0] GapLoad   = 9'(2 * CLK_DIV - 1);
    localparam logic [5:0] SclkEnd   = 6'(2 * FrameLen);
    localparam logic [5:0] LastPhase = 6'(2 * FrameLen + 1);

    logic                busy_q, busy_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [5:0]          phase_q, phase_d;
    logic [8:0]          gap_q, gap_d;
    logic [FrameLen-1:0] tx_q, tx_d;
    logic [7:0]          rx_q, rx_d;
    logic                ncs_q, ncs_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                tick;

    assign tick    = busy_q && (cnt_q == DivLast);
    assign done_o  = tick && (phase_q == LastPhase);
    assign ready_o = !busy_q && (gap_q == '0);
    assign rx_o    = rx_q;
    assign ncs_o   = ncs_q;
    assign sclk_o  = sclk_q;
    assign mosi_o  = mosi_q;

    // Next-state: half-period sequencing, MOSI shift on SCLK fall, MISO capture on SCLK rise.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        ncs_d   = ncs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        if (!busy_q) begin
            if (gap_q != '0) begin
                gap_d = gap_q - 9'd1;
            end
            if (start_i && ready_o) begin
                busy_d  = 1'b1;
                ncs_d   = 1'b0;
                cnt_d   = '0;
                phase_d = '0;
                tx_d    = tx_i;
                rx_d    = '0;
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + 8'd1;
            if (tick) begin
                phase_d = phase_q + 6'd1;
                if (phase_q == LastPhase) begin
                    busy_d = 1'b0;
                    ncs_d  = 1'b1;
                    mosi_d = 1'b0;
                    gap_d  = GapLoad;
                end else if (!phase_q[0] && phase_q < SclkEnd) begin
                    sclk_d = 1'b0;
                    mosi_d = tx_q[FrameLen-1];
                    tx_d   = {tx_q[FrameLen-2:0], 1'b0};
                end else if (phase_q[0] && phase_q < SclkEnd) begin
                    // Only the last eight samples survive, i.e. the data byte.
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], miso_i};
                end
            end
        end
    end

    // State registers; reset parks the bus idle (nCS/SCLK high, MOSI low).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            phase_q <= '0;
            gap_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

endmodule

// File: rtl/axis_scan.sv
// Periodic sensor poller: configures the sensor once after reset, then reads one
// register per TIC and hands the byte to the consumer with a COMPLETED/RESCAN handshake.
module axis_scan
    import axis_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [5:0]  RD_ADDR   = DefRdAddr,
    parameter logic [5:0]  INIT_ADDR = DefInitAddr,
    parameter logic [7:0]  INIT_DATA = DefInitData
) (
    input logic        MCLK,
    input logic        nRST,
    axis_scan_if.slave scan
);

    localparam logic [FrameLen-1:0] InitFrame = build_frame(1'b0, INIT_ADDR, INIT_DATA);
    localparam logic [FrameLen-1:0] RdFrame   = build_frame(1'b1, RD_ADDR, 8'h00);

    state_e              state_q, state_d;
    logic                completed_q, completed_d;
    logic [7:0]          xreg_q, xreg_d;
    logic                start;
    logic [FrameLen-1:0] tx_word;
    logic                ready;
    logic                done;
    logic [7:0]          rx_byte;
    logic                ncs;
    logic                sclk;
    logic                mosi;

    axis_scan_spi_shift16 #(
        .CLK_DIV(CLK_DIV)
    ) u_shift (
        .clk_i  (MCLK),
        .rst_ni (nRST),
        .start_i(start),
        .tx_i   (tx_word),
        .miso_i (scan.MISO),
        .ready_o(ready),
        .done_o (done),
        .rx_o   (rx_byte),
        .ncs_o  (ncs),
        .sclk_o (sclk),
        .mosi_o (mosi)
    );

    assign scan.nCS       = ncs;
    assign scan.SCLK      = sclk;
    assign scan.MOSI      = mosi;
    assign scan.COMPLETED = completed_q;
    assign scan.XREG      = xreg_q;

    // Scan FSM. A TIC arriving in WAIT while the inter-frame gap is still running is dropped.
    always_comb begin
        state_d     = state_q;
        completed_d = completed_q;
        xreg_d      = xreg_q;
        start       = 1'b0;
        tx_word     = (state_q == StInit) ? InitFrame : RdFrame;
        unique case (state_q)
            StInit: begin
                start = ready;
                if (done) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (scan.TIC && ready) begin
                    start   = 1'b1;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (done) begin
                    xreg_d      = rx_byte;
                    completed_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (scan.RESCAN) begin
                    completed_d = 1'b0;
                    state_d     = StWait;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // FSM state and consumer-visible output registers.
    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= StInit;
            completed_q <= 1'b0;
            xreg_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            completed_q <= completed_d;
            xreg_q      <= xreg_d;
        end
    end

endmodule

// File: tb/tb_axis_scan.sv
// Bench for axis_scan: a bus monitor records every SPI frame and plays the sensor
// on MISO; scenario tasks push expected frames and compare against what was seen.
module tb_axis_scan;

    localparam int Div = 4;

    typedef struct {
        logic [15:0] word;
        bit          rd;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        logic [15:0] word;
        int          low;
        int          falls;
        int          rises;
        int          gap;
        bit          gap_valid;
        logic        comp_before;
        logic        comp;
        logic [7:0]  xreg;
    } obs_t;

    logic MCLK = 1'b0;
    logic nRST = 1'b1;

    axis_scan_if scan_if ();

    axis_scan dut (
        .MCLK(MCLK),
        .nRST(nRST),
        .scan(scan_if)
    );

    always #5 MCLK = ~MCLK;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    obs_t obs_q[$];
    logic [7:0] sensor_byte = 8'h00;

    // Monitor state.
    int          frames_started = 0;
    int          frames_done = 0;
    int          rises_now = 0;
    int          idle_viol = 0;
    int          xreg_bad = 0;
    int          hi_cnt = 0;
    int          low_cnt = 0;
    int          falls = 0;
    int          cur_gap = 0;
    bit          cur_gap_valid = 1'b0;
    bit          in_frame = 1'b0;
    bit          after_reset = 1'b1;
    bit          rise_now;
    logic        prev_sclk = 1'b1;
    logic        last_comp = 1'b0;
    logic [7:0]  xreg_prev = 8'h00;
    logic [15:0] word = 16'h0000;

    always @(negedge MCLK) begin
        if (!nRST) begin
            in_frame    = 1'b0;
            after_reset = 1'b1;
            hi_cnt      = 0;
            prev_sclk   = 1'b1;
            xreg_prev   = 8'h00;
            last_comp   = 1'b0;
            scan_if.MISO = 1'b0;
        end else begin
            rise_now = 1'b0;
            if (!in_frame && scan_if.nCS === 1'b0) begin
                in_frame      = 1'b1;
                frames_started++;
                low_cnt       = 1;
                falls         = 0;
                rises_now     = 0;
                word          = 16'h0000;
                cur_gap       = hi_cnt;
                cur_gap_valid = !after_reset;
                after_reset   = 1'b0;
            end else if (in_frame && scan_if.nCS === 1'b0) begin
                low_cnt++;
                if (prev_sclk === 1'b1 && scan_if.SCLK === 1'b0) begin
                    word = {word[14:0], scan_if.MOSI};
                    scan_if.MISO = (falls >= 8) ? sensor_byte[3'(15 - falls)] : 1'b0;
                    falls++;
                end
                if (prev_sclk === 1'b0 && scan_if.SCLK === 1'b1) rises_now++;
            end else if (in_frame) begin
                in_frame = 1'b0;
                rise_now = 1'b1;
                hi_cnt   = 1;
                frames_done++;
                scan_if.MISO = 1'b0;
                obs_q.push_back('{word, low_cnt, falls, rises_now, cur_gap, cur_gap_valid,
                                  last_comp, scan_if.COMPLETED, scan_if.XREG});
            end else begin
                hi_cnt++;
                if (scan_if.SCLK !== 1'b1 || scan_if.MOSI !== 1'b0) idle_viol++;
            end
            if (scan_if.XREG !== xreg_prev && !rise_now) xreg_bad++;
            xreg_prev = scan_if.XREG;
            prev_sclk = scan_if.SCLK;
            last_comp = scan_if.COMPLETED;
        end
    end

    task automatic pulse_tic();
        @(negedge MCLK);
        scan_if.TIC = 1'b1;
        @(negedge MCLK);
        scan_if.TIC = 1'b0;
    endtask

    task automatic pulse_rescan();
        @(negedge MCLK);
        scan_if.RESCAN = 1'b1;
        @(negedge MCLK);
        scan_if.RESCAN = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string name);
        int n = 0;
        while (frames_done < target && n < 50 * Div) begin
            @(negedge MCLK);
            n++;
        end
        checks++;
        if (frames_done < target) begin
            errors++;
            $display("FAIL %s frame timeout: frames_done %0d required %0d", name, frames_done,
                     target);
        end
    endtask

    task automatic pop_pair(output exp_t e, output obs_t o, output bit ok);
        ok = (exp_q.size() > 0) && (obs_q.size() > 0);
        if (ok) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
        end
    endtask

    task automatic test_reset();
        exp_t e;
        obs_t o;
        bit   ok;
        #3 nRST = 1'b0;
        #1;
        checks++; if (scan_if.nCS !== 1'b1) begin errors++; $display("FAIL rst_ncs got %b want 1", scan_if.nCS); end
        checks++; if (scan_if.SCLK !== 1'b1) begin errors++; $display("FAIL rst_sclk got %b want 1", scan_if.SCLK); end
        checks++; if (scan_if.MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", scan_if.MOSI); end
        checks++; if (scan_if.COMPLETED !== 1'b0) begin errors++; $display("FAIL rst_completed got %b want 0", scan_if.COMPLETED); end
        checks++; if (scan_if.XREG !== 8'h00) begin errors++; $display("FAIL rst_xreg got %h want 00", scan_if.XREG); end
        exp_q.push_back('{16'h2D08, 1'b0, 8'h00});
        @(negedge MCLK);
        nRST = 1'b1;
        @(negedge MCLK);
        checks++; if (scan_if.nCS !== 1'b0) begin errors++; $display("FAIL init_start ncs got %b want 0", scan_if.nCS); end
        wait_frames(1, "init");
        pop_pair(e, o, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL init_frame missing");
        end else begin
            checks++; if (o.word !== e.word) begin errors++; $display("FAIL init_word got %h want %h", o.word, e.word); end
            checks++; if (o.low != 34 * Div) begin errors++; $display("FAIL init_low got %0d want %0d", o.low, 34 * Div); end
            checks++; if (o.falls != 16 || o.rises != 16) begin errors++; $display("FAIL init_edges got %0d/%0d want 16/16", o.falls, o.rises); end
            checks++; if (o.comp !== 1'b0) begin errors++; $display("FAIL init_completed got %b want 0", o.comp); end
        end
    endtask

    task automatic test_read(input logic [7:0] data, input string name);
        exp_t e;
        obs_t o;
        bit   ok;
        int   target;
        repeat (20) @(negedge MCLK);
        sensor_byte = data;
        target = frames_done + 1;
        exp_q.push_back('{16'hB200, 1'b1, data});
        pulse_tic();
        wait_frames(target, name);
        pop_pair(e, o, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL %s frame missing", name);
        end else begin
            checks++; if (o.word !== e.word) begin errors++; $display("FAIL %s word got %h want %h", name, o.word, e.word); end
            checks++; if (o.low != 34 * Div) begin errors++; $display("FAIL %s low got %0d want %0d", name, o.low, 34 * Div); end
            checks++; if (o.comp !== 1'b1 || o.comp_before !== 1'b0) begin errors++; $display("FAIL %s completed edge got %b->%b want 0->1", name, o.comp_before, o.comp); end
            checks++; if (o.xreg !== e.data) begin errors++; $display("FAIL %s xreg got %h want %h", name, o.xreg, e.data); end
            checks++; if (!o.gap_valid || o.gap < 2 * Div) begin errors++; $display("FAIL %s gap got %0d want >=%0d", name, o.gap, 2 * Div); end
        end
    endtask

    task automatic test_hold();
        int fs = frames_started;
        for (int i = 0; i < 10; i++) begin
            repeat (48) @(negedge MCLK);
            pulse_tic();
        end
        checks++; if (frames_started != fs) begin errors++; $display("FAIL hold_frames got %0d want %0d", frames_started, fs); end
        checks++; if (scan_if.XREG !== 8'hF3) begin errors++; $display("FAIL hold_xreg got %h want f3", scan_if.XREG); end
        checks++; if (scan_if.COMPLETED !== 1'b1) begin errors++; $display("FAIL hold_completed got %b want 1", scan_if.COMPLETED); end
        checks++; if (xreg_bad != 0) begin errors++; $display("FAIL hold_xreg_stable got %0d changes want 0", xreg_bad); end
        pulse_rescan();
        checks++; if (scan_if.COMPLETED !== 1'b0) begin errors++; $display("FAIL rescan_completed got %b want 0", scan_if.COMPLETED); end
    endtask

    task automatic test_tic_during_read();
        exp_t e;
        obs_t o;
        bit   ok;
        int   fs;
        int   n;
        repeat (20) @(negedge MCLK);
        fs = frames_started;
        sensor_byte = 8'h5A;
        exp_q.push_back('{16'hB200, 1'b1, 8'h5A});
        pulse_tic();
        for (int i = 0; i < 5; i++) begin
            repeat (15) @(negedge MCLK);
            pulse_tic();
        end
        wait_frames(frames_done + 1, "busy_tic");
        repeat (40) @(negedge MCLK);
        checks++; if (frames_started != fs + 1) begin errors++; $display("FAIL busy_tic_frames got %0d want %0d", frames_started - fs, 1); end
        pop_pair(e, o, ok);
        checks++; if (!ok || o.xreg !== e.data) begin errors++; $display("FAIL busy_tic_xreg got %h want 5a", o.xreg); end
        // Re-request immediately after RESCAN and keep TIC high until a frame starts.
        pulse_rescan();
        sensor_byte = 8'hC4;
        exp_q.push_back('{16'hB200, 1'b1, 8'hC4});
        fs = frames_started;
        n = 0;
        while (frames_started == fs && n < 40) begin
            @(negedge MCLK);
            scan_if.TIC = 1'b1;
            n++;
        end
        @(negedge MCLK);
        scan_if.TIC = 1'b0;
        wait_frames(frames_done + 1, "gap");
        pop_pair(e, o, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL gap_frame missing");
        end else begin
            checks++; if (!o.gap_valid || o.gap < 2 * Div) begin errors++; $display("FAIL gap_high got %0d want >=%0d", o.gap, 2 * Div); end
            checks++; if (o.xreg !== e.data) begin errors++; $display("FAIL gap_xreg got %h want %h", o.xreg, e.data); end
        end
        pulse_rescan();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        obs_t o;
        bit   ok;
        int   fs;
        int   fd;
        int   n = 0;
        repeat (20) @(negedge MCLK);
        sensor_byte = 8'h77;
        fs = frames_started;
        exp_q.push_back('{16'hB200, 1'b1, 8'h77});
        pulse_tic();
        while (!(frames_started == fs + 1 && rises_now >= 7) && n < 40 * Div) begin
            @(negedge MCLK);
            n++;
        end
        checks++; if (n >= 40 * Div) begin errors++; $display("FAIL midrst_reach_edge7 got %0d rises want 7", rises_now); end
        fd = frames_done;
        #2 nRST = 1'b0;
        #1;
        checks++; if (scan_if.nCS !== 1'b1 || scan_if.SCLK !== 1'b1 || scan_if.MOSI !== 1'b0) begin errors++; $display("FAIL midrst_pins got ncs %b sclk %b mosi %b want 1 1 0", scan_if.nCS, scan_if.SCLK, scan_if.MOSI); end
        checks++; if (scan_if.COMPLETED !== 1'b0) begin errors++; $display("FAIL midrst_completed got %b want 0", scan_if.COMPLETED); end
        checks++; if (scan_if.XREG !== 8'h00) begin errors++; $display("FAIL midrst_xreg got %h want 00", scan_if.XREG); end
        exp_q.delete();
        exp_q.push_back('{16'h2D08, 1'b0, 8'h00});
        repeat (3) @(negedge MCLK);
        nRST = 1'b1;
        wait_frames(fd + 1, "midrst_init");
        pop_pair(e, o, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL midrst_init missing");
        end else begin
            checks++; if (o.word !== e.word) begin errors++; $display("FAIL midrst_init_word got %h want %h", o.word, e.word); end
            checks++; if (o.comp !== 1'b0 || o.xreg !== 8'h00) begin errors++; $display("FAIL midrst_init_out got %b/%h want 0/00", o.comp, o.xreg); end
        end
    endtask

    task automatic test_tic_rescan_together();
        int fs;
        test_read(8'h3C, "pre_both");
        @(negedge MCLK);
        scan_if.TIC    = 1'b1;
        scan_if.RESCAN = 1'b1;
        fs = frames_started;
        @(negedge MCLK);
        scan_if.TIC    = 1'b0;
        scan_if.RESCAN = 1'b0;
        checks++; if (scan_if.COMPLETED !== 1'b0) begin errors++; $display("FAIL both_completed got %b want 0", scan_if.COMPLETED); end
        repeat (100) @(negedge MCLK);
        checks++; if (frames_started != fs) begin errors++; $display("FAIL both_no_frame got %0d frames want 0", frames_started - fs); end
        test_read(8'h9E, "after_both");
        checks++; if (idle_viol != 0) begin errors++; $display("FAIL idle_pins got %0d violations want 0", idle_viol); end
        checks++; if (xreg_bad != 0) begin errors++; $display("FAIL xreg_stable got %0d changes want 0", xreg_bad); end
    endtask

    initial begin
        scan_if.TIC    = 1'b0;
        scan_if.RESCAN = 1'b0;
        test_reset();
        test_read(8'hF3, "read_f3");
        test_hold();
        test_tic_during_read();
        test_reset_mid();
        test_tic_rescan_together();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
